// File: rtl/pc_fetch.sv
// pc_fetch: program counter, start/done handshake, jump-target table
// and saturating run-cycle counter feeding the instruction ROM.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   req          start / restart pulse from the harness
//   halt         decoder: current instruction is halt
//   branch_en    decoder: current instruction is a branch/jump
//   branch_taken ALU condition, qualified by branch_en
//   target_idx   jump-table index carried in the instruction
//   lut_we       jump-table write enable
//   lut_addr     jump-table write index
//   lut_data     jump-table write data (absolute PC)
//   pc           registered PC, drives the ROM address
//   running      high while in RUN
//   done         program finished, held until next req
//   cycle_count  instructions executed in current/last run
module pc_fetch #(
  parameter int          PC_W       = 10,
  parameter int          TGT_W      = 5,
  parameter int unsigned START_ADDR = 0,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             halt,
  input  logic             branch_en,
  input  logic             branch_taken,
  input  logic [TGT_W-1:0] target_idx,
  input  logic             lut_we,
  input  logic [TGT_W-1:0] lut_addr,
  input  logic [PC_W-1:0]  lut_data,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DEPTH = 2 ** TGT_W;

  localparam logic [PC_W-1:0] START = PC_W'(START_ADDR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  logic [PC_W-1:0] tbl [DEPTH];

  logic [PC_W-1:0]  tgt;
  logic [PC_W-1:0]  pc_inc;
  logic [CNT_W-1:0] cnt_inc;

  logic do_start;
  logic do_halt;
  logic do_jump;
  logic do_step;

  // Table read sees the pre-write entry: the write below is
  // non-blocking, so a same-edge write lands after the jump.
  always_comb begin
    tgt     = tbl[target_idx];
    pc_inc  = pc + PC_W'(1);
    cnt_inc = cycle_count;
    if (cycle_count != '1) begin
      cnt_inc = cycle_count + CNT_W'(1);
    end
  end

  // One-hot RUN action select in priority order:
  // restart, halt, taken branch, sequential step.
  always_comb begin
    do_start = req;
    do_halt  = !req && halt;
    do_jump  = !req && !halt && branch_en && branch_taken;
    do_step  = !req && !halt && !(branch_en && branch_taken);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= '0;
      running     <= 1'b0;
      done        <= 1'b0;
      cycle_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= '0;
      end
    end else begin
      if (lut_we) begin
        tbl[lut_addr] <= lut_data;
      end
      unique case (state)
        IDLE, DONE: begin
          if (req) begin
            state       <= RUN;
            pc          <= START;
            cycle_count <= '0;
            running     <= 1'b1;
            done        <= 1'b0;
          end
        end
        RUN: begin
          unique case (1'b1)
            do_start: begin
              pc          <= START;
              cycle_count <= '0;
            end
            do_halt: begin
              state   <= DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end
            do_jump: begin
              pc          <= tgt;
              cycle_count <= cnt_inc;
            end
            do_step: begin
              pc          <= pc_inc;
              cycle_count <= cnt_inc;
            end
            default: begin
              pc <= pc;
            end
          endcase
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed bench for pc_fetch with a per-cycle
// reference model plus literal spot checks.
module tb_pc_fetch;

  localparam int PW = 10;
  localparam int TW = 5;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          req;
  logic          halt;
  logic          branch_en;
  logic          branch_taken;
  logic [TW-1:0] target_idx;
  logic          lut_we;
  logic [TW-1:0] lut_addr;
  logic [PW-1:0] lut_data;
  logic [PW-1:0] pc;
  logic          running;
  logic          done;
  logic [CW-1:0] cycle_count;

  logic          req2;
  logic          zero1;
  logic [1:0]    zidx;
  logic [3:0]    zdat;
  logic [3:0]    pc2;
  logic          running2;
  logic          done2;
  logic [3:0]    cnt2;

  pc_fetch #(
    .PC_W(PW), .TGT_W(TW), .START_ADDR(0), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .halt(halt),
    .branch_en(branch_en), .branch_taken(branch_taken),
    .target_idx(target_idx), .lut_we(lut_we),
    .lut_addr(lut_addr), .lut_data(lut_data),
    .pc(pc), .running(running), .done(done),
    .cycle_count(cycle_count)
  );

  pc_fetch #(
    .PC_W(4), .TGT_W(2), .START_ADDR(0), .CNT_W(4)
  ) dut2 (
    .clk(clk), .reset(reset), .req(req2), .halt(zero1),
    .branch_en(zero1), .branch_taken(zero1),
    .target_idx(zidx), .lut_we(zero1),
    .lut_addr(zidx), .lut_data(zdat),
    .pc(pc2), .running(running2), .done(done2),
    .cycle_count(cnt2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: 0 idle, 1 run, 2 done.
  int m_st  = 0;
  int m_pc  = 0;
  int m_cnt = 0;
  int m_tbl [32];

  always @(posedge clk) begin
    int t;
    if (!reset) begin
      m_st  = 0;
      m_pc  = 0;
      m_cnt = 0;
      for (int i = 0; i < 32; i++) m_tbl[i] = 0;
    end else begin
      t = m_tbl[target_idx];
      if (lut_we) m_tbl[lut_addr] = int'(lut_data);
      if (m_st != 1) begin
        if (req) begin
          m_st  = 1;
          m_pc  = 0;
          m_cnt = 0;
        end
      end else if (req) begin
        m_pc  = 0;
        m_cnt = 0;
      end else if (halt) begin
        m_st = 2;
      end else begin
        if (branch_en && branch_taken) m_pc = t;
        else m_pc = (m_pc + 1) % (1 << PW);
        if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
      end
    end
    #1;
    chk("m_pc", 32'(pc), m_pc);
    chk("m_running", 32'(running), 32'(m_st == 1));
    chk("m_done", 32'(done), 32'(m_st == 2));
    chk("m_count", 32'(cycle_count), m_cnt);
  end

  task automatic clr();
    req          = 1'b0;
    halt         = 1'b0;
    branch_en    = 1'b0;
    branch_taken = 1'b0;
    target_idx   = '0;
    lut_we       = 1'b0;
    lut_addr     = '0;
    lut_data     = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start();
    req = 1'b1;
    tick(1);
    req = 1'b0;
  endtask

  task automatic stop();
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    lut_we   = 1'b1;
    lut_addr = TW'(a);
    lut_data = PW'(d);
    tick(1);
    lut_we   = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int visits;
    int fives;
    reset = 1'b0;
    req2  = 1'b0;
    zero1 = 1'b0;
    zidx  = '0;
    zdat  = '0;
    clr();
    tick(1);
    repeat (2) begin
      req          = 1'($urandom);
      halt         = 1'($urandom);
      branch_en    = 1'($urandom);
      branch_taken = 1'($urandom);
      target_idx   = TW'($urandom);
      lut_we       = 1'b1;
      lut_addr     = TW'($urandom);
      lut_data     = PW'($urandom);
      tick(1);
    end
    reset = 1'b1;
    clr();
    chk("rst_pc", 32'(pc), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_count", 32'(cycle_count), 0);

    // Every table entry must read back 0 after reset.
    start();
    for (int i = 0; i < 32; i++) begin
      branch_en    = 1'b1;
      branch_taken = 1'b1;
      target_idx   = TW'(i);
      tick(1);
      chk("tbl_zero", 32'(pc), 0);
    end
    clr();
    chk("tbl_count", 32'(cycle_count), 32);
    stop();

    // Straight-line run to pc 30.
    start();
    chk("sl_start_pc", 32'(pc), 0);
    chk("sl_start_run", 32'(running), 1);
    tick(30);
    chk("sl_pc30", 32'(pc), 30);
    stop();
    chk("sl_done", 32'(done), 1);
    chk("sl_running", 32'(running), 0);
    chk("sl_count", 32'(cycle_count), 30);
    tick(3);
    chk("sl_hold_pc", 32'(pc), 30);
    chk("sl_hold_done", 32'(done), 1);

    // bne loop: table[3]=5, branch at pc 8 nine times.
    wr(3, 5);
    start();
    visits = 0;
    fives  = 0;
    for (int c = 0; c < 200 && m_st != 2; c++) begin
      clr();
      if (m_pc == 5) fives++;
      if (m_pc == 8) begin
        branch_en    = 1'b1;
        branch_taken = (visits < 9);
        target_idx   = 5'd3;
        visits++;
      end
      if (m_pc == 12) halt = 1'b1;
      tick(1);
    end
    clr();
    chk("loop_fives", fives, 10);
    chk("loop_visits", visits, 10);
    chk("loop_done", 32'(done), 1);
    chk("loop_pc", 32'(pc), 12);
    chk("loop_count", 32'(cycle_count), 48);

    // Halt beats a taken branch.
    start();
    tick(3);
    halt         = 1'b1;
    branch_en    = 1'b1;
    branch_taken = 1'b1;
    target_idx   = 5'd3;
    tick(1);
    clr();
    chk("pri_done", 32'(done), 1);
    chk("pri_pc", 32'(pc), 3);
    chk("pri_count", 32'(cycle_count), 3);

    // Same-cycle write and jump uses the old entry.
    wr(2, 40);
    start();
    branch_en    = 1'b1;
    branch_taken = 1'b1;
    target_idx   = 5'd2;
    lut_we       = 1'b1;
    lut_addr     = 5'd2;
    lut_data     = 10'd100;
    tick(1);
    clr();
    chk("rw_old", 32'(pc), 40);
    chk("rw_count", 32'(cycle_count), 1);
    branch_en    = 1'b1;
    branch_taken = 1'b1;
    target_idx   = 5'd2;
    tick(1);
    clr();
    chk("rw_new", 32'(pc), 100);
    branch_taken = 1'b1;
    tick(1);
    clr();
    chk("taken_no_en", 32'(pc), 101);
    branch_en = 1'b1;
    target_idx = 5'd2;
    tick(1);
    clr();
    chk("en_not_taken", 32'(pc), 102);
    stop();

    // Restart mid-run, then mid-run reset.
    start();
    tick(12);
    chk("rs_pc12", 32'(pc), 12);
    start();
    chk("rs_pc", 32'(pc), 0);
    chk("rs_count", 32'(cycle_count), 0);
    chk("rs_running", 32'(running), 1);
    tick(7);
    chk("mr_pc7", 32'(pc), 7);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    chk("mr_pc", 32'(pc), 0);
    chk("mr_running", 32'(running), 0);
    chk("mr_done", 32'(done), 0);
    chk("mr_count", 32'(cycle_count), 0);
    halt         = 1'b1;
    branch_en    = 1'b1;
    branch_taken = 1'b1;
    tick(2);
    clr();
    chk("idle_pc", 32'(pc), 0);
    chk("idle_running", 32'(running), 0);
    chk("idle_done", 32'(done), 0);

    // Restart from DONE.
    start();
    tick(5);
    stop();
    chk("dn_done", 32'(done), 1);
    chk("dn_pc", 32'(pc), 5);
    start();
    chk("dn_clear", 32'(done), 0);
    chk("dn_run", 32'(running), 1);
    chk("dn_pc0", 32'(pc), 0);
    chk("dn_count0", 32'(cycle_count), 0);
    tick(2);
    chk("dn_pc2", 32'(pc), 2);
    stop();

    // Narrow instance: PC wraps at 16, count saturates at 15.
    req2 = 1'b1;
    tick(1);
    req2 = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      chk("wrap_pc", 32'(pc2), i % 16);
      chk("sat_count", 32'(cnt2), (i > 15) ? 15 : i);
      tick(1);
    end
    chk("wrap_running", 32'(running2), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
